// File: rtl/bist_pkg.sv
// Shared widths, MISR polynomial and FSM state encoding for the BIST response analyzer.
package bist_pkg;

    localparam int MISR_WIDTH = 16;
    localparam int RESP_WIDTH = 7;
    localparam logic [MISR_WIDTH-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register: left shift with 0x1021 feedback, response XORed into the low bits.
module bist_misr
    import bist_pkg::*;
#(
    parameter logic [MISR_WIDTH-1:0] SEED = '0
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic                  i_enable,
    input  logic [RESP_WIDTH-1:0] i_data,
    output logic [MISR_WIDTH-1:0] o_signature
);

    logic [MISR_WIDTH-1:0] r_sig;
    logic [MISR_WIDTH-1:0] w_next_sig;

    always_comb begin
        w_next_sig = {r_sig[MISR_WIDTH-2:0], 1'b0}
                   ^ (r_sig[MISR_WIDTH-1] ? MISR_POLY : '0)
                   ^ {{(MISR_WIDTH-RESP_WIDTH){1'b0}}, i_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_load) begin
            r_sig <= SEED;
        end else if (i_enable) begin
            r_sig <= w_next_sig;
        end
    end

    assign o_signature = r_sig;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST output response analyzer: compacts N_PATTERNS CUT responses into a MISR and compares with GOLDEN_SIG.
// Define BIST_ORA_MASK_EN to add the i_resp_mask input that forces masked response bits to zero.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned           N_PATTERNS = 200,
    parameter logic [MISR_WIDTH-1:0] GOLDEN_SIG = 16'h0000,
    parameter logic [MISR_WIDTH-1:0] SEED       = 16'h0000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_capture_valid,
    input  logic [RESP_WIDTH-1:0] i_resp_in,
`ifdef BIST_ORA_MASK_EN
    input  logic [RESP_WIDTH-1:0] i_resp_mask,
`endif
    output logic                  o_busy,
    output logic                  o_bist_end,
    output logic                  o_pass_nfail,
    output logic [MISR_WIDTH-1:0] o_signature,
    output logic [15:0]           o_resp_count
);

    localparam logic [15:0] LAST_COUNT = 16'(N_PATTERNS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [15:0]           r_resp_count;
    logic                  r_bist_end;
    logic                  r_pass_nfail;
    logic                  w_accept_start;
    logic                  w_absorb;
    logic [RESP_WIDTH-1:0] w_resp;
    logic [MISR_WIDTH-1:0] w_signature;

`ifdef BIST_ORA_MASK_EN
    assign w_resp = i_resp_in & ~i_resp_mask;
`else
    assign w_resp = i_resp_in;
`endif

    // Start is only honoured between sessions; responses only count while compacting.
    assign w_accept_start = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_absorb       = i_capture_valid && (r_state == ST_COMPACT);

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_accept_start) w_next_state = ST_COMPACT;
            ST_COMPACT:       if (w_absorb && (r_resp_count == LAST_COUNT)) w_next_state = ST_COMPARE;
            ST_COMPARE:       w_next_state = ST_DONE;
            default:          w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_resp_count <= '0;
            r_bist_end   <= 1'b0;
            r_pass_nfail <= 1'b0;
        end else if (w_accept_start) begin
            r_resp_count <= '0;
            r_bist_end   <= 1'b0;
            r_pass_nfail <= 1'b0;
        end else begin
            if (w_absorb) r_resp_count <= r_resp_count + 16'd1;
            if (r_state == ST_COMPARE) begin
                r_bist_end   <= 1'b1;
                r_pass_nfail <= (w_signature == GOLDEN_SIG);
            end
        end
    end

    bist_misr #(
        .SEED(SEED)
    ) u_misr (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_load     (w_accept_start),
        .i_enable   (w_absorb),
        .i_data     (w_resp),
        .o_signature(w_signature)
    );

    assign o_busy       = (r_state == ST_COMPACT) || (r_state == ST_COMPARE);
    assign o_bist_end   = r_bist_end;
    assign o_pass_nfail = r_pass_nfail;
    assign o_signature  = w_signature;
    assign o_resp_count = r_resp_count;

endmodule
